// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter
//   Selects one of NUM_CH producer channels and forwards its data word to a single
//   shared consumer through one registered output stage. The channel is chosen
//   either directly through sel (mode=0) or by round-robin arbitration over the
//   valid channels (mode=1). Both sides use valid/ready handshakes. A word can be
//   accepted in the same cycle the held word is consumed, so throughput is
//   1 word/cycle.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous reset, active-high
//   mode       0 = direct select via sel, 1 = round-robin
//   sel        channel select, used only when mode=0
//   in_data    channel c occupies in_data[c*WIDTH +: WIDTH]
//   in_valid   per-channel data valid
//   in_ready   per-channel accept, one-hot or zero
//   out_data   registered selected data
//   out_ch     index of the channel that supplied out_data
//   out_valid  out_data/out_ch valid
//   out_ready  consumer accepts the output
module rr_mux_arbiter #(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 3,
  parameter int SEL_W  = $clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]       in_valid,
  output logic [NUM_CH-1:0]       in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_ch,
  output logic                    out_valid,
  input  logic                    out_ready
);

  logic [WIDTH-1:0] data_p0;
  logic [SEL_W-1:0] ch_p0;
  logic             vld_p0;
  logic [SEL_W-1:0] ptr;

  logic             load;
  logic             cand_hit;
  logic [SEL_W-1:0] cand;
  logic [WIDTH-1:0] cand_data;
  logic             xfer;

  // First valid channel scanning ptr, ptr+1, ..., wrapping at NUM_CH (which need
  // not be a power of two). Returns {found, index}.
  function automatic logic [SEL_W:0] rr_pick(input logic [NUM_CH-1:0] v,
                                             input logic [SEL_W-1:0]  p);
    logic             found;
    logic [SEL_W-1:0] pick;
    logic [SEL_W-1:0] idx_s;
    int               idx;
    found = 1'b0;
    pick  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = int'(p) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      idx_s = SEL_W'(idx);
      if (!found && v[idx_s]) begin
        found = 1'b1;
        pick  = idx_s;
      end
    end
    return {found, pick};
  endfunction

  function automatic logic [SEL_W-1:0] ptr_next(input logic [SEL_W-1:0] c);
    return (int'(c) == NUM_CH - 1) ? '0 : c + 1'b1;
  endfunction

  // The output register can take a word when empty or when its word leaves now.
  assign load = !vld_p0 || out_ready;

  // Candidate choice never looks at in_ready, so there is no handshake loop.
  always_comb begin
    logic [SEL_W:0] rr;
    rr       = rr_pick(in_valid, ptr);
    cand_hit = 1'b0;
    cand     = '0;
    if (!mode) begin
      cand_hit = (int'(sel) < NUM_CH);
      cand     = sel;
    end else begin
      cand_hit = rr[SEL_W];
      cand     = rr[SEL_W-1:0];
    end
  end

  // In direct mode the selected channel is offered ready even when it is not
  // valid; a transfer still needs both.
  always_comb begin
    in_ready  = '0;
    cand_data = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (cand == SEL_W'(c)) begin
        in_ready[c] = !rst && load && cand_hit;
        cand_data   = in_data[c*WIDTH +: WIDTH];
      end
    end
  end

  assign xfer = |(in_valid & in_ready);

  // ---- stage p0: output register and round-robin pointer ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p0  <= 1'b0;
      data_p0 <= '0;
      ch_p0   <= '0;
      ptr     <= '0;
    end else if (xfer) begin
      vld_p0  <= 1'b1;
      data_p0 <= cand_data;
      ch_p0   <= cand;
      if (mode) ptr <= ptr_next(cand);
    end else if (out_ready) begin
      // Word consumed with nothing new: drop valid, keep last data/channel.
      vld_p0 <= 1'b0;
    end
  end

  assign out_data  = data_p0;
  assign out_ch    = ch_p0;
  assign out_valid = vld_p0;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// tb_rr_mux_arbiter
//   Self-checking bench for rr_mux_arbiter with NUM_CH=4, WIDTH=3. Directed
//   vectors with hand-computed outputs, followed by a random mode/sel/valid run.
//   Every predicted transfer is pushed into a scoreboard queue; a monitor pops
//   and compares whenever the output handshake fires.
module tb_rr_mux_arbiter;
  localparam int NUM_CH = 4;
  localparam int WIDTH  = 3;
  localparam int SEL_W  = 2;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    mode;
  logic [SEL_W-1:0]        sel;
  logic [NUM_CH*WIDTH-1:0] in_data;
  logic [NUM_CH-1:0]       in_valid;
  logic [NUM_CH-1:0]       in_ready;
  logic [WIDTH-1:0]        out_data;
  logic [SEL_W-1:0]        out_ch;
  logic                    out_valid;
  logic                    out_ready;

  always #5 clk = ~clk;

  rr_mux_arbiter #(.NUM_CH(NUM_CH), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .mode(mode), .sel(sel),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  typedef struct packed {
    logic [SEL_W-1:0] ch;
    logic [WIDTH-1:0] data;
  } word_t;

  word_t sb[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  logic  chk_en  = 1'b0;
  logic  m_vld   = 1'b0;
  logic [1:0] m_ptr = 2'd0;

  function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // Reference grant: direct sel, or first valid from m_ptr with 2-bit wrap (N=4).
  function automatic void model_grant(output logic hit, output logic [1:0] c);
    logic [1:0] idx;
    hit = 1'b0;
    c   = 2'd0;
    if (!mode) begin
      hit = 1'b1;
      c   = sel;
    end else begin
      for (int k = 3; k >= 0; k--) begin
        idx = m_ptr + 2'(k);
        if (in_valid[idx]) begin
          hit = 1'b1;
          c   = idx;
        end
      end
    end
  endfunction

  // Reference state update at the clock edge.
  always @(posedge clk or posedge rst) begin
    logic       hit;
    logic [1:0] c;
    if (rst) begin
      m_vld <= 1'b0;
      m_ptr <= 2'd0;
      sb.delete();
    end else begin
      model_grant(hit, c);
      if (hit && (!m_vld || out_ready) && in_valid[c]) begin
        m_vld <= 1'b1;
        if (mode) m_ptr <= c + 2'd1;
      end else if (out_ready) begin
        m_vld <= 1'b0;
      end
    end
  end

  // Stimulus side: predict in_ready and push predicted transfers.
  always @(negedge clk) begin
    logic       hit;
    logic [1:0] c;
    logic [3:0] exp_rdy;
    if (rst) begin
      check("in_ready_in_reset", 32'(in_ready), 32'd0);
    end else if (chk_en) begin
      model_grant(hit, c);
      exp_rdy = (hit && (!m_vld || out_ready)) ? (4'b0001 << c) : 4'b0000;
      check("in_ready", 32'(in_ready), 32'(exp_rdy));
      check("out_valid", 32'(out_valid), 32'(m_vld));
      if (exp_rdy != 4'b0000 && in_valid[c])
        sb.push_back({c, in_data[int'(c)*WIDTH +: WIDTH]});
    end
  end

  // Monitor: pop on every output handshake.
  always @(negedge clk) begin
    word_t w;
    if (!rst && chk_en && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_underflow: got ch=%0d data=%b, expected no word", out_ch, out_data);
      end else begin
        w = sb.pop_front();
        check("sb_ch", 32'(out_ch), 32'(w.ch));
        check("sb_data", 32'(out_data), 32'(w.data));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(string nm, logic [2:0] d, logic [1:0] ch);
    check({nm, "_valid"}, 32'(out_valid), 32'd1);
    check({nm, "_data"}, 32'(out_data), 32'(d));
    check({nm, "_ch"}, 32'(out_ch), 32'(ch));
  endtask

  initial begin
    rst = 1'b1; mode = 1'b0; sel = 2'd0; in_data = '0; in_valid = '0; out_ready = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_ch", 32'(out_ch), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    chk_en = 1'b1;

    // Direct select: ch3=111 ch2=010 ch1=011 ch0=100
    mode = 1'b0; sel = 2'd2; in_valid = 4'b1111; out_ready = 1'b1;
    in_data = {3'b111, 3'b010, 3'b011, 3'b100};
    #1 check("dir_ready_sel2", 32'(in_ready), 32'b0100);
    tick(); expect_out("dir_sel2", 3'b010, 2'd2);
    sel = 2'd3;
    #1 check("dir_ready_sel3", 32'(in_ready), 32'b1000);
    tick(); expect_out("dir_sel3", 3'b111, 2'd3);
    in_valid = 4'b0000;
    tick();
    check("dir_drain_valid", 32'(out_valid), 32'd0);
    check("dir_drain_data", 32'(out_data), 32'b111);
    check("dir_drain_ch", 32'(out_ch), 32'd3);

    // Round robin, all valid: ch0..3 = 101,110,010,001, no bubbles
    mode = 1'b1; in_valid = 4'b1111;
    in_data = {3'b001, 3'b010, 3'b110, 3'b101};
    tick(); expect_out("rr0", 3'b101, 2'd0);
    tick(); expect_out("rr1", 3'b110, 2'd1);
    tick(); expect_out("rr2", 3'b010, 2'd2);
    tick(); expect_out("rr3", 3'b001, 2'd3);
    tick(); expect_out("rr4", 3'b101, 2'd0);
    in_valid = 4'b0000;
    tick(); check("rr_drain_valid", 32'(out_valid), 32'd0);

    // Round robin, valid=1010; ptr is 1, first grant ch1 moves ptr to 2
    in_valid = 4'b1010;
    tick(); expect_out("rrs_a", 3'b110, 2'd1);
    tick(); expect_out("rrs_b", 3'b001, 2'd3);
    tick(); expect_out("rrs_c", 3'b110, 2'd1);
    tick(); expect_out("rrs_d", 3'b001, 2'd3);
    tick(); expect_out("rrs_e", 3'b110, 2'd1);
    in_valid = 4'b0000;
    tick(); check("rrs_drain_valid", 32'(out_valid), 32'd0);
    // ptr held at 2 across idle cycles: next grant is ch2
    tick();
    in_valid = 4'b1111;
    #1 check("ptr_hold_ready", 32'(in_ready), 32'b0100);
    tick(); expect_out("ptr_hold", 3'b010, 2'd2);

    // Backpressure for 3 cycles
    out_ready = 1'b0;
    #1 check("bp_ready", 32'(in_ready), 32'b0000);
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_out("bp_hold", 3'b010, 2'd2);
      check("bp_ready_hold", 32'(in_ready), 32'b0000);
    end
    out_ready = 1'b1;
    #1 check("bp_release_ready", 32'(in_ready), 32'b1000);
    tick(); expect_out("bp_release", 3'b001, 2'd3);

    // Asynchronous reset mid-stream with out_valid=1
    #2 rst = 1'b1;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_out_data", 32'(out_data), 32'd0);
    check("arst_out_ch", 32'(out_ch), 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'b0000);
    tick();
    rst = 1'b0;
    #1 check("arst_ptr0_ready", 32'(in_ready), 32'b0001);
    tick(); expect_out("arst_after", 3'b101, 2'd0);

    // Random run, checked through the model and the scoreboard
    for (int i = 0; i < 1000; i++) begin
      mode      = 1'($urandom);
      sel       = 2'($urandom);
      in_valid  = 4'($urandom);
      in_data   = 12'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end

    in_valid = 4'b0000; out_ready = 1'b1;
    tick(); tick(); tick();
    check("final_out_valid", 32'(out_valid), 32'd0);
    check("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
